csr_rmw_ctrl: RTL and testbench

CSR_RMW_CTRL -- requirements
Module: csr_rmw_ctrl

---
 rtl/csr_rmw_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_csr_rmw_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_rmw_ctrl.sv
// csr_rmw_ctrl: sequences CSR read-modify-write ops (and vsetvl when CSR_VSETVL_EN is defined)
// against an external CSR file whose read data follows the registered read address by one cycle.
//
// state | meaning
// IDLE  | waiting for start; illegal funct3 / unsupported vset rejected here
// RD    | read address presented (vset: read back VL_ADDR, then report vl)
// CAP   | old value captured (vset: done pulse with new vl)
// WR    | write strobe + done, or illegal for a write to a read-only CSR (vset: first step)
module csr_rmw_ctrl #(
  parameter logic [11:0] VL_ADDR = 12'hC20,
  parameter logic [8:0]  MAX_VL  = 9'd256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  rs1_idx,
  input  logic        is_vset,
  input  logic        freeze,
  input  logic [31:0] csr_rddata,
  output logic [11:0] csr_adr_rd,
  output logic [11:0] csr_adr_wr,
  output logic [31:0] csr_wrdata,
  output logic        csr_wr_en,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        illegal
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_WR} state_t;

`ifdef CSR_VSETVL_EN
  localparam bit VSET_EN = 1'b1;
`else
  localparam bit VSET_EN = 1'b0;
`endif

  state_t      r_state;
  state_t      w_state_nxt;

  logic [2:0]  r_funct3;
  logic [11:0] r_addr;
  logic [31:0] r_rs1_data;
  logic [4:0]  r_rs1_idx;
  logic        r_vset;
  logic [31:0] r_old;
  logic [31:0] w_old_nxt;

  logic [11:0] r_adr_rd;
  logic [11:0] r_adr_wr;
  logic [31:0] r_wrdata;
  logic [31:0] r_rd_data;
  logic        r_wr_en;
  logic        r_done;
  logic        r_illegal;
  logic        r_busy;

  logic [11:0] w_adr_rd_nxt;
  logic [11:0] w_adr_wr_nxt;
  logic [31:0] w_wrdata_nxt;
  logic [31:0] w_rd_data_nxt;
  logic        w_wr_en_nxt;
  logic        w_done_nxt;
  logic        w_illegal_nxt;

  logic        w_accept;
  logic        w_hold;
  logic [31:0] w_operand;
  logic [31:0] w_new;
  logic        w_writes;
  logic        w_ro;
  logic [8:0]  w_vl;

  assign w_accept  = (r_state == S_IDLE) && start && !freeze;
  assign w_hold    = (r_state != S_IDLE) && freeze;
  assign w_operand = r_funct3[2] ? {27'd0, r_rs1_idx} : r_rs1_data;
  assign w_writes  = (r_funct3[1:0] == 2'b01) || (r_rs1_idx != 5'd0);
  assign w_ro      = (r_addr[11:10] == 2'b11);
  assign w_vl      = (r_rs1_data == 32'd0) ? MAX_VL : csr_rddata[8:0];

  always_comb begin
    w_new = w_operand;
    case (r_funct3[1:0])
      2'b10:   w_new = r_old | w_operand;
      2'b11:   w_new = r_old & ~w_operand;
      default: w_new = w_operand;
    endcase
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_adr_rd_nxt  = r_adr_rd;
    w_adr_wr_nxt  = r_adr_wr;
    w_wrdata_nxt  = r_wrdata;
    w_rd_data_nxt = r_rd_data;
    w_old_nxt     = r_old;
    w_wr_en_nxt   = 1'b0;
    w_done_nxt    = 1'b0;
    w_illegal_nxt = 1'b0;

    if (w_hold) begin
      w_wr_en_nxt   = r_wr_en;
      w_done_nxt    = r_done;
      w_illegal_nxt = r_illegal;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (is_vset) begin
              if (VSET_EN) begin
                w_state_nxt  = S_WR;
                w_wr_en_nxt  = 1'b1;
                w_adr_wr_nxt = VL_ADDR;
                w_wrdata_nxt = rs1_data;
              end else begin
                w_illegal_nxt = 1'b1;
              end
            end else if (funct3[1:0] == 2'b00) begin
              w_illegal_nxt = 1'b1;
            end else begin
              w_state_nxt  = S_RD;
              w_adr_rd_nxt = csr_addr;
            end
          end
        end
        S_RD: begin
          w_state_nxt = S_CAP;
          if (r_vset) begin
            w_done_nxt    = 1'b1;
            w_rd_data_nxt = {23'd0, w_vl};
          end else begin
            w_old_nxt = csr_rddata;
          end
        end
        S_CAP: begin
          if (r_vset) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_WR;
            if (w_ro && w_writes) begin
              w_illegal_nxt = 1'b1;
            end else begin
              w_wr_en_nxt   = w_writes;
              w_done_nxt    = 1'b1;
              w_rd_data_nxt = r_old;
              w_adr_wr_nxt  = r_addr;
              w_wrdata_nxt  = w_new;
            end
          end
        end
        S_WR: begin
          if (r_vset) begin
            w_state_nxt  = S_RD;
            w_adr_rd_nxt = VL_ADDR;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_adr_rd  <= '0;
      r_adr_wr  <= '0;
      r_wrdata  <= '0;
      r_rd_data <= '0;
      r_old     <= '0;
      r_wr_en   <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_adr_rd  <= w_adr_rd_nxt;
      r_adr_wr  <= w_adr_wr_nxt;
      r_wrdata  <= w_wrdata_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_old     <= w_old_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_done    <= w_done_nxt;
      r_illegal <= w_illegal_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_funct3   <= '0;
      r_addr     <= '0;
      r_rs1_data <= '0;
      r_rs1_idx  <= '0;
      r_vset     <= 1'b0;
    end else if (w_accept) begin
      r_funct3   <= funct3;
      r_addr     <= csr_addr;
      r_rs1_data <= rs1_data;
      r_rs1_idx  <= rs1_idx;
      r_vset     <= is_vset;
    end
  end

  // Strobes stay registered and held through a stall, but are masked so a frozen cycle never writes or completes.
  assign csr_wr_en  = r_wr_en & ~freeze;
  assign done       = r_done & ~freeze;
  assign csr_adr_rd = r_adr_rd;
  assign csr_adr_wr = r_adr_wr;
  assign csr_wrdata = r_wrdata;
  assign rd_data    = r_rd_data;
  assign illegal    = r_illegal;
  assign busy       = r_busy;

endmodule

// File: tb/tb_csr_rmw_ctrl.sv
// Bench for csr_rmw_ctrl: directed vector table, randomized ops against a behavioural model,
// and hand sequences for reset/stall corner cases. CSR file modelled as a 4K-word array.
module tb_csr_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, is_vset, freeze;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  rs1_idx;
  logic [31:0] csr_rddata;
  logic [11:0] csr_adr_rd, csr_adr_wr;
  logic [31:0] csr_wrdata, rd_data;
  logic        csr_wr_en, busy, done, illegal;

  always #5 clk = ~clk;

  csr_rmw_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .csr_addr(csr_addr),
    .rs1_data(rs1_data), .rs1_idx(rs1_idx), .is_vset(is_vset), .freeze(freeze),
    .csr_rddata(csr_rddata), .csr_adr_rd(csr_adr_rd), .csr_adr_wr(csr_adr_wr),
    .csr_wrdata(csr_wrdata), .csr_wr_en(csr_wr_en), .busy(busy), .done(done),
    .rd_data(rd_data), .illegal(illegal)
  );

  logic [31:0] mem [4096];
  logic        pre_en = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  int          wr_count = 0;
  logic [11:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  assign csr_rddata = mem[csr_adr_rd];

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (csr_wr_en) begin
      mem[csr_adr_wr] <= csr_wrdata;
      wr_count        <= wr_count + 1;
      last_waddr      <= csr_adr_wr;
      last_wdata      <= csr_wrdata;
    end
  end

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] d;
    logic [4:0]  idx;
    logic        vs;
    logic [31:0] init;
    int          fz_from;
    int          fz_len;
    int          e_done;
    int          e_ill;
    int          e_nwr;
    logic [11:0] e_waddr;
    logic [31:0] e_wdata;
    logic [31:0] e_rd;
  } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] rd_hold = '0;
  vec_t        tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preset(input logic [11:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Reference: outcome of one request from the instruction-level rules, with stall cycles simply added.
  function automatic vec_t model(input vec_t v);
    vec_t        e;
    logic [31:0] op;
    int          dly;
    logic        writes;
    e = v;
    op = v.f3[2] ? {27'd0, v.idx} : v.d;
    dly = (v.fz_len > 0 && (v.fz_from == 1 || v.fz_from == 2)) ? v.fz_len : 0;
    writes = (v.f3[1:0] == 2'b01) || (v.idx != 5'd0);
    e.e_done = -1; e.e_ill = -1; e.e_nwr = 0;
    e.e_waddr = '0; e.e_wdata = '0; e.e_rd = '0;
    if (v.vs) begin
`ifdef CSR_VSETVL_EN
      e.e_done  = 3;
      e.e_nwr   = 1;
      e.e_waddr = 12'hC20;
      e.e_wdata = v.d;
      e.e_rd    = (v.d == 32'd0) ? 32'd256 : {23'd0, v.d[8:0]};
`else
      e.e_ill = 1;
`endif
    end else if (v.f3[1:0] == 2'b00) begin
      e.e_ill = 1;
    end else if (v.addr[11:10] == 2'b11 && writes) begin
      e.e_ill = 3 + dly;
    end else begin
      e.e_done  = 3 + dly;
      e.e_rd    = v.init;
      e.e_nwr   = writes ? 1 : 0;
      e.e_waddr = v.addr;
      case (v.f3[1:0])
        2'b01:   e.e_wdata = op;
        2'b10:   e.e_wdata = v.init | op;
        default: e.e_wdata = v.init & ~op;
      endcase
    end
    return e;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int          wr0, n_done, n_ill, got_done, got_ill, last;
    logic [10:0] bmask, emask;
    logic [31:0] exp_rd;
    preset(v.addr, v.init);
    wr0 = wr_count;
    start = 1'b1; funct3 = v.f3; csr_addr = v.addr; rs1_data = v.d;
    rs1_idx = v.idx; is_vset = v.vs;
    got_done = -1; got_ill = -1; n_done = 0; n_ill = 0; bmask = '0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0; funct3 = 3'b000; csr_addr = ~v.addr; rs1_data = ~v.d;
        rs1_idx = ~v.idx; is_vset = 1'b0;
      end
      if (done) begin
        n_done++;
        if (got_done < 0) got_done = n;
      end
      if (illegal) begin
        n_ill++;
        if (got_ill < 0) got_ill = n;
      end
      bmask[n] = busy;
      freeze = (n >= v.fz_from && n < v.fz_from + v.fz_len);
    end
    freeze = 1'b0;
    last = (v.e_done > 0) ? v.e_done : ((v.e_ill > 1) ? v.e_ill : 0);
    emask = '0;
    for (int n = 1; n <= 10; n++) emask[n] = (n <= last);
    exp_rd = (v.e_done > 0) ? v.e_rd : rd_hold;
    chk($sformatf("%s done_cycle", tag), got_done, v.e_done);
    chk($sformatf("%s done_count", tag), n_done, (v.e_done > 0) ? 1 : 0);
    chk($sformatf("%s illegal_cycle", tag), got_ill, v.e_ill);
    chk($sformatf("%s illegal_count", tag), n_ill, (v.e_ill > 0) ? 1 : 0);
    chk($sformatf("%s write_count", tag), wr_count - wr0, v.e_nwr);
    if (v.e_nwr > 0) begin
      chk($sformatf("%s write_addr", tag), {20'd0, last_waddr}, {20'd0, v.e_waddr});
      chk($sformatf("%s write_data", tag), last_wdata, v.e_wdata);
    end
    chk($sformatf("%s rd_data", tag), rd_data, exp_rd);
    chk($sformatf("%s busy_trace", tag), {21'd0, bmask}, {21'd0, emask});
    rd_hold = exp_rd;
  endtask

  initial begin
    int wr0, n_ill, n_done;
    rst = 1'b1; start = 1'b0; is_vset = 1'b0; freeze = 1'b0;
    funct3 = '0; csr_addr = '0; rs1_data = '0; rs1_idx = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset strobes", {29'd0, done, illegal, csr_wr_en}, 32'd0);
    chk("reset rd_data", rd_data, 32'd0);
    chk("reset addrs", {8'd0, csr_adr_rd, csr_adr_wr}, 32'd0);
    rst = 1'b0;

    // f3, addr, d, idx, vs, init, fz_from, fz_len, e_done, e_ill, e_nwr, e_waddr, e_wdata, e_rd
    tbl[0]  = '{3'b010, 12'h300, 32'h80,       5'd5,  1'b0, 32'h8,        0, 0, 3, -1, 1, 12'h300, 32'h88,       32'h8};
    tbl[1]  = '{3'b111, 12'h305, 32'hFFFF,     5'd0,  1'b0, 32'h12345678, 0, 0, 3, -1, 0, 12'h0,   32'h0,        32'h12345678};
    tbl[2]  = '{3'b100, 12'h300, 32'h1,        5'd1,  1'b0, 32'h3,        0, 0, -1, 1, 0, 12'h0,   32'h0,        32'h0};
    tbl[3]  = '{3'b001, 12'hF11, 32'h55,       5'd3,  1'b0, 32'h600D,     0, 0, -1, 3, 0, 12'h0,   32'h0,        32'h0};
    tbl[4]  = '{3'b001, 12'h340, 32'hDEADBEEF, 5'd9,  1'b0, 32'h11,       0, 0, 3, -1, 1, 12'h340, 32'hDEADBEEF, 32'h11};
    tbl[5]  = '{3'b011, 12'h341, 32'hF0,       5'd7,  1'b0, 32'hFF,       0, 0, 3, -1, 1, 12'h341, 32'h0F,       32'hFF};
    tbl[6]  = '{3'b101, 12'h342, 32'hAAAA,     5'd31, 1'b0, 32'h5,        0, 0, 3, -1, 1, 12'h342, 32'h1F,       32'h5};
    tbl[7]  = '{3'b110, 12'h343, 32'h0,        5'd3,  1'b0, 32'h10,       0, 0, 3, -1, 1, 12'h343, 32'h13,       32'h10};
    tbl[8]  = '{3'b010, 12'hC00, 32'h0,        5'd0,  1'b0, 32'h77,       0, 0, 3, -1, 0, 12'h0,   32'h0,        32'h77};
    tbl[9]  = '{3'b001, 12'h344, 32'h9,        5'd2,  1'b0, 32'h42,       2, 3, 6, -1, 1, 12'h344, 32'h9,        32'h42};
    tbl[10] = '{3'b000, 12'h344, 32'h1,        5'd1,  1'b0, 32'h0,        0, 0, -1, 1, 0, 12'h0,   32'h0,        32'h0};
`ifdef CSR_VSETVL_EN
    tbl[11] = '{3'b111, 12'h000, 32'h0,        5'd0,  1'b1, 32'h0,        0, 0, 3, -1, 1, 12'hC20, 32'h0,        32'h100};
`else
    tbl[11] = '{3'b111, 12'h000, 32'h0,        5'd0,  1'b1, 32'h0,        0, 0, -1, 1, 0, 12'h0,   32'h0,        32'h0};
`endif
    tbl[12] = '{3'b111, 12'hC01, 32'h0,        5'd4,  1'b0, 32'hFF,       0, 0, -1, 3, 0, 12'h0,   32'h0,        32'h0};
    tbl[13] = '{3'b010, 12'h345, 32'h3,        5'd6,  1'b0, 32'h10,       1, 2, 5, -1, 1, 12'h345, 32'h13,       32'h10};

    for (int i = 0; i < 14; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.f3   = 3'($urandom_range(0, 7));
      v.addr = ($urandom_range(0, 3) == 0) ? 12'hC00 + 12'($urandom_range(0, 15))
                                           : 12'h300 + 12'($urandom_range(0, 63));
      v.d    = $urandom;
      v.idx  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      v.vs   = ($urandom_range(0, 7) == 0);
      v.init = $urandom;
      v.fz_from = 0;
      v.fz_len  = 0;
      if (!v.vs && $urandom_range(0, 2) == 0) begin
        v.fz_from = $urandom_range(1, 2);
        v.fz_len  = $urandom_range(1, 3);
      end
      v = model(v);
      run_vec($sformatf("rnd%0d", i), v);
    end

    // Reset in CAP abandons the write.
    preset(12'h350, 32'hA5);
    wr0 = wr_count;
    start = 1'b1; funct3 = 3'b001; csr_addr = 12'h350; rs1_data = 32'h1; rs1_idx = 5'd1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_cap busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst_cap busy", {31'd0, busy}, 32'd0);
    chk("rst_cap strobes", {29'd0, done, illegal, csr_wr_en}, 32'd0);
    chk("rst_cap rd_data", rd_data, 32'd0);
    chk("rst_cap wrdata", csr_wrdata, 32'd0);
    chk("rst_cap addrs", {8'd0, csr_adr_rd, csr_adr_wr}, 32'd0);
    n_done = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); @(negedge clk);
      if (done) n_done++;
    end
    chk("rst_cap no_done", n_done, 0);
    chk("rst_cap no_write", wr_count - wr0, 0);
    rd_hold = '0;

    // Start during freeze in IDLE is ignored.
    start = 1'b1; freeze = 1'b1; funct3 = 3'b000;
    @(posedge clk); @(negedge clk);
    start = 1'b0; freeze = 1'b0;
    chk("frz_idle ignored", {30'd0, busy, illegal}, 32'd0);

    // A second start while busy is ignored.
    preset(12'h360, 32'h1);
    wr0 = wr_count;
    start = 1'b1; funct3 = 3'b001; csr_addr = 12'h360; rs1_data = 32'h5; rs1_idx = 5'd2;
    n_ill = 0; n_done = 0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); @(negedge clk);
      start = (n == 1); funct3 = 3'b000;
      if (illegal) n_ill++;
      if (done) n_done++;
    end
    start = 1'b0;
    chk("busy_start no_illegal", n_ill, 0);
    chk("busy_start done_count", n_done, 1);
    chk("busy_start write", last_wdata, 32'h5);
    chk("busy_start write_count", wr_count - wr0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
